// File: rtl/conv1d_pkg.sv
// conv1d_pkg: command codes, kernel geometry and sequencer states shared by
// the conv1d command sequencer and its buffer streamer.
package conv1d_pkg;
  localparam logic [6:0] CMD_NOP       = 7'd0;
  localparam logic [6:0] CMD_WR_INPUT  = 7'd10;
  localparam logic [6:0] CMD_WR_WEIGHT = 7'd11;
  localparam logic [6:0] CMD_OFFSET    = 7'd20;
  localparam logic [6:0] CMD_WIDTH     = 7'd25;
  localparam logic [6:0] CMD_DEPTH     = 7'd26;
  localparam logic [6:0] CMD_START     = 7'd41;
  localparam logic [6:0] CMD_READ_ACC  = 7'd43;
  localparam logic [6:0] CMD_SHIFT     = 7'd44;
  localparam logic [6:0] CMD_STATUS    = 7'd45;

  localparam int KERNEL_LENGTH      = 8;
  localparam int MAX_INPUT_CHANNELS = 128;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_W, S_LOAD_I, S_P_OFF, S_P_DEPTH, S_P_SHIFT,
    S_START, S_POLL, S_POLL_WAIT, S_READ, S_READ_WAIT, S_RESULT
  } state_e;

  function automatic logic [10:0] buf_len(input logic [31:0] depth);
    return 11'(KERNEL_LENGTH) * depth[10:0];
  endfunction
endpackage

// File: rtl/conv1d_buf_streamer.sv
// conv1d_buf_streamer: reads len bytes from local memory and forwards each one
// as a CFU write one cycle later; start is held for the whole N+1 cycle run.
module conv1d_buf_streamer
  import conv1d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [10:0] len_i,
  input  logic [6:0]  cmd_code_i,
  input  logic [7:0]  mem_rd_data_i,
  output logic        mem_rd_en_o,
  output logic [9:0]  mem_rd_addr_o,
  output logic [6:0]  cfu_cmd_o,
  output logic [31:0] cfu_inp0_o,
  output logic [31:0] cfu_inp1_o,
  output logic        done_o
);
  logic [10:0] rd_k_q, rd_k_d;
  logic [9:0]  wr_k_q;
  logic        wr_q;

  assign mem_rd_en_o   = start_i && rd_k_q != len_i;
  assign mem_rd_addr_o = mem_rd_en_o ? rd_k_q[9:0] : '0;
  // the final write is the only write cycle with every read already issued
  assign done_o        = wr_q && rd_k_q == len_i;
  assign cfu_cmd_o     = wr_q ? cmd_code_i : CMD_NOP;
  assign cfu_inp0_o    = wr_q ? {22'b0, wr_k_q} : '0;
  assign cfu_inp1_o    = wr_q ? {24'b0, mem_rd_data_i} : '0;

  always_comb rd_k_d = done_o ? '0 : mem_rd_en_o ? rd_k_q + 11'd1 : rd_k_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_k_q <= '0;
      wr_k_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      rd_k_q <= rd_k_d;
      wr_q   <= mem_rd_en_o;
      if (mem_rd_en_o) wr_k_q <= rd_k_q[9:0];
    end
  end
endmodule

// File: rtl/conv1d_cmd_sequencer.sv
// conv1d_cmd_sequencer: runs one conv1d job over the CFU command interface
// (buffer loads, parameters, start, status poll, accumulator read).
module conv1d_cmd_sequencer
  import conv1d_pkg::*;
#(
  parameter int POLL_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_depth,
  input  logic [31:0] job_offset,
  input  logic [31:0] job_shift,
  input  logic        job_load_w,
  input  logic        job_load_i,
  output logic        mem_rd_en,
  output logic        mem_sel,
  output logic [9:0]  mem_rd_addr,
  input  logic [7:0]  mem_rd_data,
  output logic [6:0]  cfu_cmd,
  output logic [31:0] cfu_inp0,
  output logic [31:0] cfu_inp1,
  input  logic [31:0] cfu_ret,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_error
);
  state_e      state_q, state_d;
  logic        live_q;
  logic [31:0] depth_q, offset_q, shift_q;
  logic        load_i_q;
  logic [9:0]  poll_q, poll_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_error_q, res_error_d;
  logic        accept, bad_depth, st_start, st_done;
  logic [6:0]  st_cmd;
  logic [31:0] st_inp0, st_inp1;

  assign job_ready = live_q && state_q == S_IDLE;
  assign accept    = job_valid && job_ready;
  assign bad_depth = job_depth == '0 || job_depth > 32'(MAX_INPUT_CHANNELS);
  assign st_start  = state_q == S_LOAD_W || state_q == S_LOAD_I;
  assign mem_sel   = state_q == S_LOAD_W;
  assign res_valid = state_q == S_RESULT;
  assign res_data  = res_data_q;
  assign res_error = res_error_q;

  conv1d_buf_streamer u_streamer (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (st_start),
    .len_i         (buf_len(depth_q)),
    .cmd_code_i    (state_q == S_LOAD_W ? CMD_WR_WEIGHT : CMD_WR_INPUT),
    .mem_rd_data_i (mem_rd_data),
    .mem_rd_en_o   (mem_rd_en),
    .mem_rd_addr_o (mem_rd_addr),
    .cfu_cmd_o     (st_cmd),
    .cfu_inp0_o    (st_inp0),
    .cfu_inp1_o    (st_inp1),
    .done_o        (st_done)
  );

  always_comb begin
    state_d     = state_q;
    poll_d      = poll_q;
    res_data_d  = res_data_q;
    res_error_d = res_error_q;
    case (state_q)
      S_IDLE: if (accept) begin
        poll_d      = '0;
        res_data_d  = '0;
        res_error_d = bad_depth;
        state_d     = bad_depth ? S_RESULT : job_load_w ? S_LOAD_W : job_load_i ? S_LOAD_I : S_P_OFF;
      end
      S_LOAD_W:  if (st_done) state_d = load_i_q ? S_LOAD_I : S_P_OFF;
      S_LOAD_I:  if (st_done) state_d = S_P_OFF;
      S_P_OFF:   state_d = S_P_DEPTH;
      S_P_DEPTH: state_d = S_P_SHIFT;
      S_P_SHIFT: state_d = S_START;
      S_START:   state_d = S_POLL;
      S_POLL:    state_d = S_POLL_WAIT;
      S_POLL_WAIT: if (cfu_ret[0]) state_d = S_READ;
        else begin
          poll_d = poll_q + 10'd1;
          if (poll_d == 10'(POLL_TIMEOUT)) begin
            state_d     = S_RESULT;
            res_error_d = 1'b1;
            res_data_d  = '0;
          end else state_d = S_POLL;
        end
      S_READ:      state_d = S_READ_WAIT;
      S_READ_WAIT: begin
        res_data_d  = cfu_ret;
        res_error_d = 1'b0;
        state_d     = S_RESULT;
      end
      S_RESULT: if (res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // commands are decoded from the current state so reset clears them at once
  always_comb begin
    cfu_cmd  = CMD_NOP;
    cfu_inp0 = '0;
    cfu_inp1 = '0;
    case (state_q)
      S_LOAD_W, S_LOAD_I: begin
        cfu_cmd  = st_cmd;
        cfu_inp0 = st_inp0;
        cfu_inp1 = st_inp1;
      end
      S_P_OFF: begin
        cfu_cmd  = CMD_OFFSET;
        cfu_inp1 = offset_q;
      end
      S_P_DEPTH: begin
        cfu_cmd  = CMD_DEPTH;
        cfu_inp1 = depth_q;
      end
      S_P_SHIFT: begin
        cfu_cmd  = CMD_SHIFT;
        cfu_inp1 = shift_q;
      end
      S_START: cfu_cmd = CMD_START;
      S_POLL:  cfu_cmd = CMD_STATUS;
      S_READ:  cfu_cmd = CMD_READ_ACC;
      default: cfu_cmd = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      live_q      <= 1'b0;
      depth_q     <= '0;
      offset_q    <= '0;
      shift_q     <= '0;
      load_i_q    <= 1'b0;
      poll_q      <= '0;
      res_data_q  <= '0;
      res_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      poll_q      <= poll_d;
      res_data_q  <= res_data_d;
      res_error_q <= res_error_d;
      if (accept) begin
        depth_q  <= job_depth;
        offset_q <= job_offset;
        shift_q  <= job_shift;
        load_i_q <= job_load_i;
      end
    end
  end
endmodule
